// File: rtl/axis_gen_pkg.sv
// axis_frame_gen shared types and constants.
// FSM states, pattern mode codes, colour-bar palette.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_SOLID = 2'd2;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(
    input logic [2:0] n
  );
    logic [23:0] c;
    case (n)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/axis_gen_colorbar.sv
// Column position to colour-bar RGB.
// Eight equal bars; columns past bar 7 stay black.
module axis_gen_colorbar
  import axis_gen_pkg::*;
#(
  parameter int H_ACTIVE = 480,
  parameter int XW       = 9
) (
  input  logic [XW-1:0] x,
  output logic [23:0]   rgb
);

  localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [XW-1:0] bar;

  // bar number, saturated to the last bar
  always_comb begin
    bar = x / XW'(BW);
    rgb = (bar > XW'(7)) ? bar_color(3'd7)
                         : bar_color(bar[2:0]);
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream raster frame generator (tuser=SOF, tlast=EOL).
// AXIS_GEN_COLORBAR_EN builds the colour-bar pattern for mode 1.
module axis_frame_gen
  import axis_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int GAP_CYCLES = 16
) (
  input  logic        wr_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int XW = ($clog2(H_ACTIVE) < 3) ? 3
                                             : $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state, nstate;
  logic [XW-1:0] x, b_x;
  logic [YW-1:0] y, b_y;
  logic [31:0]   idx, b_idx, pix;
  logic [1:0]    mode_q, b_mode;
  logic [23:0]   rgb_q, b_rgb;
  logic [GW-1:0] gap_cnt;
  logic          last_x, last_y, xfer, eof, fresh;
  logic          gap_end, load;

  // beat acceptance and frame-end detection
  always_comb begin
    last_x  = x == XW'(H_ACTIVE - 1);
    last_y  = y == YW'(V_ACTIVE - 1);
    xfer    = m_axis_tvalid && m_axis_tready;
    eof     = xfer && last_x && last_y;
    fresh   = (state != ST_ACTIVE) || eof;
    gap_end = (state == ST_GAP) &&
              (gap_cnt == GW'(GAP_CYCLES - 1));
  end

  // coordinates and settings of the next beat
  always_comb begin
    b_x    = '0;
    b_y    = '0;
    b_idx  = '0;
    b_mode = mode;
    b_rgb  = solid_rgb;
    if (!fresh) begin
      b_x    = last_x ? '0 : x + XW'(1);
      b_y    = last_x ? y + YW'(1) : y;
      b_idx  = idx + 32'd1;
      b_mode = mode_q;
      b_rgb  = rgb_q;
    end
  end

`ifdef AXIS_GEN_COLORBAR_EN
  logic [23:0] bar_rgb;

  axis_gen_colorbar #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_bars (
    .x   (b_x),
    .rgb (bar_rgb)
  );
`endif

  // pixel value for the next beat
  always_comb begin
    pix = b_idx;
    unique case (1'b1)
      b_mode == MODE_SOLID: pix = {8'h00, b_rgb};
`ifdef AXIS_GEN_COLORBAR_EN
      b_mode == MODE_BARS:  pix = {8'h00, bar_rgb};
`endif
      default:              pix = b_idx;
    endcase
  end

  // frame sequencing: when to present a new beat
  always_comb begin
    nstate = state;
    load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          nstate = ST_ACTIVE;
          load   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          load = 1'b1;
          if (eof && GAP_CYCLES > 0) begin
            nstate = ST_GAP;
            load   = 1'b0;
          end else if (eof && !enable) begin
            nstate = ST_IDLE;
            load   = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          nstate = enable ? ST_ACTIVE : ST_IDLE;
          load   = enable;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // registered state, counters and stream outputs
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      idx           <= '0;
      mode_q        <= MODE_COUNT;
      rgb_q         <= '0;
      gap_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state      <= nstate;
      frame_done <= eof;
      busy       <= nstate != ST_IDLE;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + GW'(1)
                                      : '0;
      if (eof) begin
        frame_cnt <= frame_cnt + 16'd1;
        x         <= '0;
        y         <= '0;
        idx       <= '0;
      end
      if (load) begin
        x             <= b_x;
        y             <= b_y;
        idx           <= b_idx;
        mode_q        <= b_mode;
        rgb_q         <= b_rgb;
        m_axis_tdata  <= pix;
        m_axis_tuser  <= (b_x == '0) && (b_y == '0);
        m_axis_tlast  <= b_x == XW'(H_ACTIVE - 1);
        m_axis_tvalid <= 1'b1;
      end else if (nstate != ST_ACTIVE) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: two instances (8x4 gap 5, 16x2 gap 0).
// Beats are checked against a pixel model built from raster rules.
module tb_axis_frame_gen;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        clk = 1'b0;
  logic        rst_n, en, rdy, sel;
  logic [1:0]  mode_in;
  logic [23:0] rgb_in;
  logic        en_a, en_b;

  logic [31:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_user, b_user, c_user;
  logic        a_last, b_last, c_last;
  logic        a_fd, b_fd, c_fd;
  logic        a_busy, b_busy, c_busy;
  logic [15:0] a_cnt, b_cnt, c_cnt;

  int checks   = 0;
  int failures = 0;
  int fc_exp [2];

  always #5 clk = ~clk;

  assign en_a    = en & ~sel;
  assign en_b    = en & sel;
  assign c_data  = sel ? b_data  : a_data;
  assign c_valid = sel ? b_valid : a_valid;
  assign c_user  = sel ? b_user  : a_user;
  assign c_last  = sel ? b_last  : a_last;
  assign c_fd    = sel ? b_fd    : a_fd;
  assign c_busy  = sel ? b_busy  : a_busy;
  assign c_cnt   = sel ? b_cnt   : a_cnt;

  axis_frame_gen #(
    .H_ACTIVE (8), .V_ACTIVE (4), .GAP_CYCLES (5)
  ) u_a (
    .wr_clk (clk), .rst_n (rst_n), .enable (en_a),
    .mode (mode_in), .solid_rgb (rgb_in),
    .m_axis_tdata (a_data), .m_axis_tvalid (a_valid),
    .m_axis_tready (rdy), .m_axis_tuser (a_user),
    .m_axis_tlast (a_last), .frame_done (a_fd),
    .busy (a_busy), .frame_cnt (a_cnt)
  );

  axis_frame_gen #(
    .H_ACTIVE (16), .V_ACTIVE (2), .GAP_CYCLES (0)
  ) u_b (
    .wr_clk (clk), .rst_n (rst_n), .enable (en_b),
    .mode (mode_in), .solid_rgb (rgb_in),
    .m_axis_tdata (b_data), .m_axis_tvalid (b_valid),
    .m_axis_tready (rdy), .m_axis_tuser (b_user),
    .m_axis_tlast (b_last), .frame_done (b_fd),
    .busy (b_busy), .frame_cnt (b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input int md, input int h, input int x,
    input int p, input logic [23:0] rgb
  );
`ifdef AXIS_GEN_COLORBAR_EN
    int b;
    if (md == 1) begin
      b = x / (h / 8);
      if (b > 7) b = 7;
      return {8'h00, BARS[b]};
    end
`endif
    if (md == 2) return {8'h00, rgb};
    return 32'(p);
  endfunction

  task automatic run(input int frames, input int h,
                     input int v, input int md,
                     input logic [23:0] rgb, input bit rnd,
                     input int drop_at, input int gap_exp,
                     input int rst_at_in);
    int fsz = h * v;
    int total = frames * fsz;
    int k = 0, cyc = 0, zeros = 0, p = 0, x = 0;
    int rst_at = rst_at_in;
    bit hold = 0, fd_due = 0, gap_run = 0;
    logic [31:0] hd;
    logic hu, hl;
    mode_in = 2'(md);
    rgb_in  = rgb;
    en      = 1'b1;
    rdy     = 1'b0;
    @(posedge clk); #1;
    chk("start_busy", 32'(c_busy), 32'd1);
    chk("start_valid", 32'(c_valid), 32'd1);
    while ((k < total || fd_due) && cyc < total * 4 + 64) begin
      cyc++;
      if (hold) begin
        chk("hold_valid", 32'(c_valid), 32'd1);
        chk("hold_data", c_data, hd);
        chk("hold_user", 32'(c_user), 32'(hu));
        chk("hold_last", 32'(c_last), 32'(hl));
      end
      if (fd_due) begin
        chk("frame_done", 32'(c_fd), 32'd1);
        chk("frame_cnt", 32'(c_cnt), 32'(fc_exp[sel]));
        fd_due = 0;
      end else begin
        chk("frame_done_low", 32'(c_fd), 32'd0);
      end
      if (gap_run) begin
        if (c_valid) begin
          chk("gap_len", 32'(zeros), 32'(gap_exp));
          gap_run = 0;
        end else begin
          zeros++;
        end
      end
      if (k == rst_at) begin
        rst_n  = 1'b0;
        rst_at = -1;
        @(posedge clk); #1;
        chk("rst_valid", 32'(c_valid), 32'd0);
        chk("rst_data", c_data, 32'd0);
        chk("rst_user", 32'(c_user), 32'd0);
        chk("rst_last", 32'(c_last), 32'd0);
        chk("rst_fd", 32'(c_fd), 32'd0);
        chk("rst_busy", 32'(c_busy), 32'd0);
        chk("rst_cnt", 32'(c_cnt), 32'd0);
        fc_exp[0] = 0;
        fc_exp[1] = 0;
        k = 0; hold = 0; fd_due = 0; gap_run = 0;
        mode_in = 2'(md);
        rgb_in  = rgb;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        chk("rst_restart", 32'(c_valid), 32'd1);
        continue;
      end
      if (k >= drop_at) en = 1'b0;
      if (frames == 1 && k == 5) begin
        mode_in = 2'($urandom);
        rgb_in  = 24'($urandom);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k < total && c_valid && rdy) begin
        p = k % fsz;
        x = p % h;
        chk("beat_data", c_data, model(md, h, x, p, rgb));
        chk("beat_user", 32'(c_user), 32'(p == 0));
        chk("beat_last", 32'(c_last), 32'(x == h - 1));
        k++;
        if (p == fsz - 1) begin
          fd_due = 1;
          fc_exp[sel] = (fc_exp[sel] + 1) & 'hFFFF;
          if (k < total) begin
            gap_run = 1;
            zeros   = 0;
          end
        end
        hold = 0;
      end else begin
        hold = c_valid;
        hd   = c_data;
        hu   = c_user;
        hl   = c_last;
      end
      @(posedge clk); #1;
    end
    if (k < total || fd_due)
      chk("timeout", 32'(k + int'(fd_due)), 32'(total));
    rdy = 1'b1;
    en  = 1'b0;
    repeat (gap_exp + 3) @(posedge clk);
    #1;
    chk("end_valid", 32'(c_valid), 32'd0);
    chk("end_busy", 32'(c_busy), 32'd0);
    chk("end_cnt", 32'(c_cnt), 32'(fc_exp[sel]));
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    rdy       = 1'b0;
    sel       = 1'b0;
    mode_in   = 2'd0;
    rgb_in    = 24'd0;
    fc_exp[0] = 0;
    fc_exp[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(a_valid), 32'd0);
    chk("reset_data", a_data, 32'd0);
    chk("reset_user", 32'(a_user), 32'd0);
    chk("reset_last", 32'(a_last), 32'd0);
    chk("reset_fd", 32'(a_fd), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_cnt", 32'(a_cnt), 32'd0);
    chk("reset_b_valid", 32'(b_valid), 32'd0);
    chk("reset_b_cnt", 32'(b_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", 32'(a_valid), 32'd0);

    // 8x4 gap 5: pulse, backpressure, solid, reserved mode
    run(1, 8, 4, 0, 24'd0, 1'b0, 0, 5, -1);
    run(1, 8, 4, 0, 24'd0, 1'b1, 0, 5, -1);
    run(2, 8, 4, 2, 24'($urandom), 1'b0, 63, 5, -1);
    run(1, 8, 4, 3, 24'd0, 1'b1, 0, 5, -1);
    run(1, 8, 4, 1, 24'd0, 1'b1, 0, 5, -1);
    // reset at beat 13, enable dropped at beat 20
    run(1, 8, 4, 0, 24'd0, 1'b0, 20, 5, 13);

    // 16x2 back-to-back, colour bars, random solid
    sel = 1'b1;
    run(3, 16, 2, 0, 24'd0, 1'b0, 95, 0, -1);
    run(1, 16, 2, 1, 24'd0, 1'b1, 0, 0, -1);
    run(2, 16, 2, 2, 24'($urandom), 1'b1, 63, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
